// File: rtl/vp_mem_router_pkg.sv
// Shared types, field widths and segment decode for the VP memory router.
// DEF_* values stand in for the system-level lane/width/latency defines.
package vp_mem_router_pkg;

  localparam int SEG_W          = 16;
  localparam int OFF_W          = 16;
  localparam int PORT_ID_W      = 8;
  localparam int DEF_NUM_LANE   = 4;
  localparam int DEF_LANE_W     = 16;
  localparam int DEF_SCALAR_W   = 64;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_MEMR_DELAY = 2;

  typedef enum logic [1:0] {
    TGT_SPM = 2'd0,
    TGT_KSK = 2'd1,
    TGT_ILL = 2'd2
  } mem_tgt_e;

  typedef struct packed {
    logic                 vld;
    logic [PORT_ID_W-1:0] port;
  } rd_tag_t;

  function automatic mem_tgt_e seg_decode(input logic [SEG_W-1:0] seg,
                                          input int num_seg, input int ksk_seg);
    mem_tgt_e tgt;
    if (int'(seg) < num_seg) tgt = TGT_SPM;
    else if (int'(seg) == ksk_seg) tgt = TGT_KSK;
    else tgt = TGT_ILL;
    return tgt;
  endfunction

endpackage

// File: rtl/vp_mem_router_rr_arbiter.sv
// Round-robin arbiter: priority starts at ptr_r, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         advance
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] next_ptr_s;
  int               idx_s;

  // first requester at or after the pointer wins
  always_comb begin
    grant      = '0;
    advance    = 1'b0;
    next_ptr_s = ptr_r;
    idx_s      = 0;
    for (int i = 0; i < N; i++) begin
      idx_s = (int'(ptr_r) + i) % N;
      if (!advance && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        advance      = 1'b1;
        next_ptr_s   = PTR_W'((idx_s + 1) % N);
      end else begin
        advance = advance;
      end
    end
  end

  // pointer only moves when something was granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_r <= '0;
    else if (advance) ptr_r <= next_ptr_s;
    else ptr_r <= ptr_r;
  end

endmodule

// File: rtl/vp_mem_router.sv
// Routes LSU load/store requests to SPM/KSK ports via segment base pointers
// and returns read data to the issuing port after the fixed memory latency.
module vp_mem_router
  import vp_mem_router_pkg::*;
#(
  parameter int NUM_PORT   = 2,
  parameter int NUM_SEG    = 4,
  parameter int KSK_SEG    = 15,
  parameter int SEG_LSB    = 48,
  parameter int OFF_LSB    = $clog2(DEF_NUM_LANE) + $clog2(DEF_LANE_W / 8),
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_NUM_LANE * DEF_LANE_W,
  parameter int MEMR_DELAY = DEF_MEMR_DELAY,
  parameter int SCALAR_W   = DEF_SCALAR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORT-1:0]          i_rd_vld,
  input  logic [NUM_PORT*SCALAR_W-1:0] i_rd_addr,
  output logic [NUM_PORT-1:0]          o_rd_rdy,
  input  logic [NUM_PORT-1:0]          i_wr_vld,
  input  logic [NUM_PORT*SCALAR_W-1:0] i_wr_addr,
  input  logic [NUM_PORT*DATA_W-1:0]   i_wr_data,
  output logic [NUM_PORT-1:0]          o_wr_rdy,
  output logic [NUM_PORT-1:0]          o_rsp_vld,
  output logic [NUM_PORT*DATA_W-1:0]   o_rsp_data,
  input  logic [NUM_SEG*SCALAR_W-1:0]  i_csr_seg_ptr,
  input  logic [SCALAR_W-1:0]          i_csr_ksk_ptr,
  output logic                         o_spm_rden,
  output logic [ADDR_W-1:0]            o_spm_rdaddr,
  input  logic [DATA_W-1:0]            i_spm_rdata,
  output logic                         o_spm_wren,
  output logic [ADDR_W-1:0]            o_spm_wraddr,
  output logic [DATA_W-1:0]            o_spm_wdata,
  output logic                         o_ksk_rden,
  output logic [ADDR_W-1:0]            o_ksk_rdaddr,
  input  logic [DATA_W-1:0]            i_ksk_rdata,
  input  logic                         i_err_clr,
  output logic                         o_err
);

  function automatic logic [ADDR_W-1:0] phys_addr(input logic [SCALAR_W-1:0] addr,
                                                  input logic [NUM_SEG*SCALAR_W-1:0] seg_ptr,
                                                  input logic [SCALAR_W-1:0] ksk_ptr);
    logic [SEG_W-1:0]    seg;
    logic [SCALAR_W-1:0] base;
    seg  = addr[SEG_LSB +: SEG_W];
    base = ksk_ptr;
    for (int s = 0; s < NUM_SEG; s++) begin
      if (int'(seg) == s) base = seg_ptr[s*SCALAR_W +: SCALAR_W];
      else base = base;
    end
    return ADDR_W'(addr[OFF_LSB +: OFF_W]) + base[ADDR_W-1:0];
  endfunction

  logic [NUM_PORT-1:0]  spm_rd_req_s, ksk_rd_req_s, spm_wr_req_s, ill_rd_s, ill_wr_s;
  logic [NUM_PORT-1:0]  spm_rd_gnt_s, ksk_rd_gnt_s, spm_wr_gnt_s;
  logic                 spm_rd_adv_s, ksk_rd_adv_s, spm_wr_adv_s;
  logic [ADDR_W-1:0]    rd_phys_s [NUM_PORT];
  logic [ADDR_W-1:0]    wr_phys_s [NUM_PORT];
  logic [ADDR_W-1:0]    spm_rd_addr_s, ksk_rd_addr_s, spm_wr_addr_s;
  logic [DATA_W-1:0]    spm_wr_data_s;
  logic [PORT_ID_W-1:0] spm_rd_port_s, ksk_rd_port_s;
  rd_tag_t              spm_tag_r [MEMR_DELAY+1];
  rd_tag_t              ksk_tag_r [MEMR_DELAY+1];
  logic                 spm_rden_r, ksk_rden_r, spm_wren_r, err_r;
  logic [ADDR_W-1:0]    spm_rdaddr_r, ksk_rdaddr_r, spm_wraddr_r;
  logic [DATA_W-1:0]    spm_wdata_r;

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    mem_tgt_e rd_tgt_s, wr_tgt_s;
    logic     spm_hit_s, ksk_hit_s;

    assign rd_tgt_s        = seg_decode(i_rd_addr[p*SCALAR_W+SEG_LSB +: SEG_W], NUM_SEG, KSK_SEG);
    assign wr_tgt_s        = seg_decode(i_wr_addr[p*SCALAR_W+SEG_LSB +: SEG_W], NUM_SEG, KSK_SEG);
    assign rd_phys_s[p]    = phys_addr(i_rd_addr[p*SCALAR_W +: SCALAR_W], i_csr_seg_ptr, i_csr_ksk_ptr);
    assign wr_phys_s[p]    = phys_addr(i_wr_addr[p*SCALAR_W +: SCALAR_W], i_csr_seg_ptr, i_csr_ksk_ptr);
    assign spm_rd_req_s[p] = i_rd_vld[p] && (rd_tgt_s == TGT_SPM);
    assign ksk_rd_req_s[p] = i_rd_vld[p] && (rd_tgt_s == TGT_KSK);
    assign ill_rd_s[p]     = i_rd_vld[p] && (rd_tgt_s == TGT_ILL);
    assign spm_wr_req_s[p] = i_wr_vld[p] && (wr_tgt_s == TGT_SPM);
    // KSK is read-only, so a KSK write is treated like an illegal segment
    assign ill_wr_s[p]     = i_wr_vld[p] && (wr_tgt_s != TGT_SPM);

    assign o_rd_rdy[p] = rst_n & (spm_rd_gnt_s[p] | ksk_rd_gnt_s[p] | ill_rd_s[p]);
    assign o_wr_rdy[p] = rst_n & (spm_wr_gnt_s[p] | ill_wr_s[p]);

    assign spm_hit_s = spm_tag_r[MEMR_DELAY].vld && (spm_tag_r[MEMR_DELAY].port == PORT_ID_W'(p));
    assign ksk_hit_s = ksk_tag_r[MEMR_DELAY].vld && (ksk_tag_r[MEMR_DELAY].port == PORT_ID_W'(p));
    assign o_rsp_vld[p] = spm_hit_s | ksk_hit_s;
    assign o_rsp_data[p*DATA_W +: DATA_W] = spm_hit_s ? i_spm_rdata :
                                            (ksk_hit_s ? i_ksk_rdata : '0);
  end

  rr_arbiter #(.N(NUM_PORT)) u_spm_rd_arb (
    .clk(clk), .rst_n(rst_n), .req(spm_rd_req_s), .grant(spm_rd_gnt_s), .advance(spm_rd_adv_s));
  rr_arbiter #(.N(NUM_PORT)) u_ksk_rd_arb (
    .clk(clk), .rst_n(rst_n), .req(ksk_rd_req_s), .grant(ksk_rd_gnt_s), .advance(ksk_rd_adv_s));
  rr_arbiter #(.N(NUM_PORT)) u_spm_wr_arb (
    .clk(clk), .rst_n(rst_n), .req(spm_wr_req_s), .grant(spm_wr_gnt_s), .advance(spm_wr_adv_s));

  // one-hot grant select of the winning address, data and port id
  always_comb begin
    spm_rd_addr_s = '0;
    ksk_rd_addr_s = '0;
    spm_wr_addr_s = '0;
    spm_wr_data_s = '0;
    spm_rd_port_s = '0;
    ksk_rd_port_s = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      spm_rd_addr_s |= spm_rd_gnt_s[p] ? rd_phys_s[p] : '0;
      spm_rd_port_s |= spm_rd_gnt_s[p] ? PORT_ID_W'(p) : '0;
      ksk_rd_addr_s |= ksk_rd_gnt_s[p] ? rd_phys_s[p] : '0;
      ksk_rd_port_s |= ksk_rd_gnt_s[p] ? PORT_ID_W'(p) : '0;
      spm_wr_addr_s |= spm_wr_gnt_s[p] ? wr_phys_s[p] : '0;
      spm_wr_data_s |= spm_wr_gnt_s[p] ? i_wr_data[p*DATA_W +: DATA_W] : '0;
    end
  end

  // registered issue, tag pipelines and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spm_rden_r   <= 1'b0;
      ksk_rden_r   <= 1'b0;
      spm_wren_r   <= 1'b0;
      spm_rdaddr_r <= '0;
      ksk_rdaddr_r <= '0;
      spm_wraddr_r <= '0;
      spm_wdata_r  <= '0;
      err_r        <= 1'b0;
      for (int k = 0; k <= MEMR_DELAY; k++) begin
        spm_tag_r[k] <= '0;
        ksk_tag_r[k] <= '0;
      end
    end else begin
      spm_rden_r   <= spm_rd_adv_s;
      ksk_rden_r   <= ksk_rd_adv_s;
      spm_wren_r   <= spm_wr_adv_s;
      spm_rdaddr_r <= spm_rd_addr_s;
      ksk_rdaddr_r <= ksk_rd_addr_s;
      spm_wraddr_r <= spm_wr_addr_s;
      spm_wdata_r  <= spm_wr_data_s;
      spm_tag_r[0] <= '{vld: spm_rd_adv_s, port: spm_rd_port_s};
      ksk_tag_r[0] <= '{vld: ksk_rd_adv_s, port: ksk_rd_port_s};
      for (int k = 1; k <= MEMR_DELAY; k++) begin
        spm_tag_r[k] <= spm_tag_r[k-1];
        ksk_tag_r[k] <= ksk_tag_r[k-1];
      end
      // a new error wins over a clear in the same cycle
      if (|{ill_rd_s, ill_wr_s}) err_r <= 1'b1;
      else if (i_err_clr) err_r <= 1'b0;
      else err_r <= err_r;
    end
  end

  assign o_spm_rden   = spm_rden_r;
  assign o_spm_rdaddr = spm_rdaddr_r;
  assign o_ksk_rden   = ksk_rden_r;
  assign o_ksk_rdaddr = ksk_rdaddr_r;
  assign o_spm_wren   = spm_wren_r;
  assign o_spm_wraddr = spm_wraddr_r;
  assign o_spm_wdata  = spm_wdata_r;
  assign o_err        = err_r;

endmodule
